// File: rtl/asip_pkg.sv
// Shared definitions for the stepper-motor ASIP sequencer: opcodes, FSM states,
// instruction field positions and register-file geometry.
package asip_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned REG_AW   = 2;
  localparam int unsigned INST_W   = 16;

  // Instruction word fields: opcode | rd | rs | imm
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 10;
  localparam int unsigned RS_MSB  = 9;
  localparam int unsigned RS_LSB  = 8;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LDL  = 4'h3;
  localparam logic [3:0] OP_LDH  = 4'h4;
  localparam logic [3:0] OP_OUT  = 4'h5;
  localparam logic [3:0] OP_WAIT = 4'h6;
  localparam logic [3:0] OP_JNZ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'h9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WAIT
  } state_e;

endpackage

// File: rtl/asip_regfile.sv
// 4x8 general-purpose register file: two combinational read ports and one
// synchronous write port. All registers clear on reset.
module asip_regfile
  import asip_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Register storage: clear on reset, single write per cycle when enabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/asip_control.sv
// Fetch/decode/execute sequencer for the stepper-motor ASIP. Drives an external
// ALU (controls + operands), writes its result back to the local register
// file, and owns the motor coil pattern and the WAIT prescaler.
//
//   state  | meaning
//   IDLE   | halted; waits for start
//   FETCH  | pc presented on inst_addr
//   DECODE | ROM data valid, captured into IR
//   EXEC   | opcode executed, writeback on the closing edge
//   WAIT   | prescaled countdown of the WAIT unit count
module asip_control
  import asip_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [INST_W-1:0] inst_data,
  output logic              alu_add_sub,
  output logic              alu_set_low,
  output logic              alu_set_high,
  output logic [DATA_W-1:0] alu_operanda,
  output logic [DATA_W-1:0] alu_operandb,
  input  logic [DATA_W-1:0] alu_result,
  output logic [3:0]        motor_phase,
  output logic              busy
);

  // TICK_DIV = 1 still needs a 1-bit prescaler that is permanently at rollover.
  localparam int unsigned     PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [INST_W-1:0]   ir_q;
  logic [3:0]          motor_q;
  logic [PRE_W-1:0]    pre_q;
  logic [DATA_W-1:0]   units_q;

  logic [3:0]          opcode;
  logic [REG_AW-1:0]   rd;
  logic [REG_AW-1:0]   rs;
  logic [7:0]          imm;
  logic [DATA_W-1:0]   rdata_a;
  logic [DATA_W-1:0]   rdata_b;
  logic                in_exec;
  logic                wr_en_d;
  logic [ADDR_W-1:0]   pc_inc_d;

  assign opcode   = ir_q[OPC_MSB:OPC_LSB];
  assign rd       = ir_q[RD_MSB:RD_LSB];
  assign rs       = ir_q[RS_MSB:RS_LSB];
  assign imm      = ir_q[IMM_MSB:IMM_LSB];
  assign in_exec  = (state_q == ST_EXEC);
  assign pc_inc_d = pc_q + ADDR_W'(1);

  assign wr_en_d = in_exec && ((opcode == OP_ADD) || (opcode == OP_SUB) ||
                               (opcode == OP_LDL) || (opcode == OP_LDH));

  asip_regfile u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .we_i      (wr_en_d),
    .waddr_i   (rd),
    .wdata_i   (alu_result),
    .raddr_a_i (rd),
    .raddr_b_i (rs),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b)
  );

  // ALU controls are decoded from IR but gated to EXEC so the ALU sees a clean
  // add (all zero) in every other state.
  assign alu_add_sub  = in_exec && (opcode == OP_SUB);
  assign alu_set_low  = in_exec && (opcode == OP_LDL);
  assign alu_set_high = in_exec && (opcode == OP_LDH);

  assign alu_operanda = rdata_a;
  assign alu_operandb = ((opcode == OP_ADD) || (opcode == OP_SUB)) ? rdata_b
                                                                   : {4'h0, imm[3:0]};

  assign inst_addr   = pc_q;
  assign motor_phase = motor_q;
  assign busy        = (state_q != ST_IDLE);

  // Sequencer: state, pc, IR, motor pattern and WAIT counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      motor_q <= '0;
      pre_q   <= '0;
      units_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pc_q    <= '0;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          ir_q    <= inst_data;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          state_q <= ST_FETCH;
          pc_q    <= pc_inc_d;
          case (opcode)
            OP_OUT: motor_q <= rdata_a[3:0];
            OP_WAIT: begin
              units_q <= rdata_a;
              pre_q   <= '0;
              if (rdata_a != '0) begin
                state_q <= ST_WAIT;
              end
            end
            OP_JNZ: begin
              if (rdata_a != '0) begin
                pc_q <= imm[ADDR_W-1:0];
              end
            end
            OP_JMP: pc_q <= imm[ADDR_W-1:0];
            OP_HALT: begin
              pc_q    <= pc_q;
              state_q <= ST_IDLE;
            end
            default: ;
          endcase
        end
        ST_WAIT: begin
          if (pre_q == PRE_LAST) begin
            pre_q   <= '0;
            units_q <= units_q - DATA_W'(1);
            if (units_q == DATA_W'(1)) begin
              state_q <= ST_FETCH;
            end
          end else begin
            pre_q <= pre_q + PRE_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/asip_control.md
# asip_control

Fetch/decode/execute sequencer for the stepper-motor ASIP. It sits directly upstream of the 8-bit ALU: it reads 16-bit instructions from an external synchronous ROM and drives the ALU's `add_sub`, `set_low` and `set_high` controls and its operands. It also writes the ALU result back into a local 4×8 register file, and drives the 4-bit motor coil pattern and timed waits.

## Interface
- `ADDR_W`, 8, program counter / instruction address width (≤ 8).
- `TICK_DIV`, 1000, clock cycles per WAIT unit (≥ 1).

Clock and reset are fixed: one clock, `clk`; reset is `reset_n`, asynchronous and active-low.

- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; in IDLE, starts execution at address 0.
- `inst_addr` out ADDR_W: ROM address; data returns one cycle later.
- `inst_data` in 16: instruction word; fields are opcode[15:12], rd[11:10], rs[9:8], imm[7:0].
- `alu_add_sub` out 1: 0 = add, 1 = subtract.
- `alu_set_low` out 1: load low nibble.
- `alu_set_high` out 1: load high nibble.
- `alu_operanda` out 8: always R[rd] of the instruction register (IR).
- `alu_operandb` out 8: R[rs] for ADD/SUB; {4'h0, imm[3:0]} otherwise.
- `alu_result` in 8: combinational ALU result.
- `motor_phase` out 4: registered coil pattern.
- `busy` out 1: high whenever the state is not IDLE.

## Operation

**States**
- IDLE: on `start`, pc = 0, go to FETCH.
- FETCH: `inst_addr` = pc, go to DECODE.
- DECODE: IR ← `inst_data`, go to EXEC.
- EXEC: execute the opcode, then go to FETCH, WAIT or IDLE.
- WAIT: count down, then go to FETCH.

**Opcodes**
- 0x0 NOP: no operation.
- 0x1 ADD: R[rd] ← R[rd] + R[rs], mod 256.
- 0x2 SUB: R[rd] ← R[rd] − R[rs], mod 256.
- 0x3 LDL: R[rd] ← {R[rd][7:4], imm[3:0]}.
- 0x4 LDH: R[rd] ← {imm[3:0], R[rd][3:0]}.
- 0x5 OUT: `motor_phase` ← R[rd][3:0].
- 0x6 WAIT: unit count ← R[rd]. If 0, go to FETCH; else go to WAIT.
- 0x7 JNZ: if R[rd] ≠ 0, pc ← imm[ADDR_W−1:0].
- 0x8 JMP: pc ← imm[ADDR_W−1:0].
- 0x9 HALT: go to IDLE; pc holds.
- 0xA–0xF: execute as NOP.

**Rules**
- ALU controls: high only in EXEC for the matching opcode; all three are 0 otherwise.
- ADD/SUB/LDL/LDH write `alu_result` to R[rd] at the end of EXEC.
- Writeback happens only in EXEC.
- rd == rs is legal: ADD doubles R[rd]; SUB yields 0.
- pc ← pc + 1, mod 2^ADDR_W, in EXEC for every opcode except a taken JNZ, JMP and HALT.
- Wrap-around from 2^ADDR_W − 1 goes to 0.
- WAIT state:
  - A prescaler counts 0 … TICK_DIV−1; each rollover decrements the unit count.
  - The transition to FETCH occurs on the rollover that takes the unit count to 0.
- `start` is ignored while `busy` is high.

**Reset values (asynchronous)**
- state = IDLE, pc = 0, IR = 0, R0–R3 = 0.
- `motor_phase` = 0, `busy` = 0, prescaler and unit counter = 0.
- Reset takes priority over every state, including mid-WAIT.

## Timing
- Non-WAIT instruction: 3 cycles (FETCH at T, DECODE at T+1, EXEC at T+2, next FETCH at T+3).
- Register writes and `motor_phase` update on the clock edge that ends EXEC.
- WAIT with R[rd] = N > 0: 3 + N·TICK_DIV cycles FETCH-to-FETCH.
- WAIT with N = 0: 3 cycles.
- `start` pulse at cycle S: FETCH at S+1, `busy` high from S+1.
- After HALT's EXEC: `busy` low on the next cycle.
- A back-to-back `start` in the cycle after HALT is accepted.
- A read-after-write in the next instruction sees the new value: DECODE/EXEC follow the write edge.

## Structure
- Package `asip_pkg`:
  - opcode localparams OP_NOP … OP_HALT
  - state enum IDLE/FETCH/DECODE/EXEC/WAIT
  - IR field bit positions
  - register count (4) and data width (8)
- Sub-module `asip_regfile`: 4×8, two combinational read ports, one synchronous write port with enable, asynchronous active-low reset to 0.
- The ALU is instantiated outside this block, beside it.

## Test plan
- Load and output: LDL r1,0x5; LDH r1,0xA; OUT r1 → R1 = 0xA5, `motor_phase` = 4'h5 nine cycles after FETCH of the first instruction.
- Arithmetic wrap: R0 = 0xF0, R1 = 0x20; ADD r0,r1 → R0 = 0x10; then SUB r2,r1 with R2 = 0 → R2 = 0xE0. Check `alu_add_sub` = 1 only in SUB's EXEC.
- Loop: R0 = 3, R1 = 1; loop: SUB r0,r1; JNZ r0,loop; HALT → SUB executes exactly 3 times, R0 = 0, `busy` falls 18 + 3 cycles after the first FETCH.
- WAIT with TICK_DIV = 4: R2 = 3 → 12 cycles in WAIT, next FETCH 15 cycles after WAIT's FETCH. R2 = 0 → next FETCH after 3 cycles.
- Reset mid-WAIT: drop `reset_n` asynchronously → same cycle `busy` = 0, `motor_phase` = 0; after release, registers read 0. A `start` pulse while busy is ignored (pc unchanged).
- Boundaries: opcode 0xF advances pc like a NOP. With ADDR_W = 4, pc wraps 15 → 0. JMP 0xFF with ADDR_W = 4 → pc = 0xF.
